// File: rtl/conv_encoder_framer.sv
// Rate-1/2 K=3 convolutional encoder that turns one byte into one 16-bit codeword per accept.
// Encoder state carries across bytes. An optional zero tail word closes each frame and returns the trellis to 00.
module conv_encoder_framer #(
  parameter logic [2:0] G0      = 3'b111,
  parameter logic [2:0] G1      = 3'b101,
  parameter bit         TAIL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic        data_last,
  output logic        data_ready,
  output logic [15:0] code_out,
  output logic        code_valid,
  output logic        code_last
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CODE_W = 2 * BYTE_W;

  typedef enum logic {
    ENC  = 1'b0,
    TAIL = 1'b1
  } state_e;

  state_e              state_q;
  logic [1:0]          s_q;
  logic [CODE_W-1:0]   code_q;
  logic                code_valid_q;
  logic                code_last_q;

  logic [BYTE_W-1:0]   enc_byte;
  logic [CODE_W-1:0]   enc_word_d;
  logic [1:0]          enc_state_d;
  logic [1:0]          s_v;
  logic [2:0]          win;
  logic                accept;

  assign data_ready = (state_q == ENC);
  assign accept     = data_valid & data_ready;

  // Unrolled eight-step encode, MSB first. The tail encodes zeros from the current state.
  always_comb begin
    enc_byte   = (state_q == TAIL) ? 8'h00 : data_in;
    enc_word_d = '0;
    s_v        = s_q;
    win        = '0;
    for (int i = BYTE_W - 1; i >= 0; i--) begin
      win                = {enc_byte[i], s_v};
      enc_word_d[2*i+1]  = ^(G0 & win);
      enc_word_d[2*i]    = ^(G1 & win);
      s_v                = {enc_byte[i], s_v[1]};
    end
    enc_state_d = s_v;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ENC;
      s_q          <= 2'b00;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      code_last_q  <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      case (state_q)
        ENC: begin
          if (accept) begin
            code_q       <= enc_word_d;
            code_valid_q <= 1'b1;
            if (data_last && TAIL_EN) begin
              code_last_q <= 1'b0;
              s_q         <= enc_state_d;
              state_q     <= TAIL;
            end else if (data_last) begin
              code_last_q <= 1'b1;
              s_q         <= 2'b00;
            end else begin
              code_last_q <= 1'b0;
              s_q         <= enc_state_d;
            end
          end
        end
        TAIL: begin
          code_q       <= enc_word_d;
          code_valid_q <= 1'b1;
          code_last_q  <= 1'b1;
          s_q          <= 2'b00;
          state_q      <= ENC;
        end
        default: state_q <= ENC;
      endcase
    end
  end

  assign code_out   = code_q;
  assign code_valid = code_valid_q;
  assign code_last  = code_last_q;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Directed bench for conv_encoder_framer: one instance with the tail word enabled, one without.
module tb_conv_encoder_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        data_last;
  logic        valid_a, valid_b;
  logic        ready_a, ready_b;
  logic [15:0] code_a, code_b;
  logic        cv_a, cv_b, cl_a, cl_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_encoder_framer #(.G0(3'b111), .G1(3'b101), .TAIL_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(valid_a), .data_last(data_last),
    .data_ready(ready_a), .code_out(code_a), .code_valid(cv_a), .code_last(cl_a)
  );

  conv_encoder_framer #(.G0(3'b111), .G1(3'b101), .TAIL_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(valid_b), .data_last(data_last),
    .data_ready(ready_b), .code_out(code_b), .code_valid(cv_b), .code_last(cl_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference: c0 = u^s1^s0, c1 = u^s0, state shifts u in at s1.
  function automatic logic [15:0] ref_enc(input logic [7:0] b, inout logic [1:0] s);
    logic [15:0] w;
    logic        u;
    w = '0;
    for (int i = 7; i >= 0; i--) begin
      u = b[i];
      w = {w[13:0], u ^ s[1] ^ s[0], u ^ s[0]};
      s = {u, s[1]};
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  bytes [4];
  logic [1:0]  s_ref;
  logic [15:0] exp_w;

  initial begin
    rst = 1'b1; data_in = 8'h00; data_last = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    tick(); tick();
    chk("rst_valid", 16'(cv_a), 16'h0);
    chk("rst_code", code_a, 16'h0000);
    chk("rst_last", 16'(cl_a), 16'h0);
    chk("rst_ready", 16'(ready_a), 16'h1);
    rst = 1'b0;

    // Impulse from s=00, then idle hold
    data_in = 8'h80; valid_a = 1'b1; tick();
    chk("imp_code", code_a, 16'hEC00);
    chk("imp_valid", 16'(cv_a), 16'h1);
    chk("imp_last", 16'(cl_a), 16'h0);
    valid_a = 1'b0; tick();
    chk("idle_valid", 16'(cv_a), 16'h0);
    chk("idle_hold", code_a, 16'hEC00);

    // State carry across bytes
    data_in = 8'hFF; valid_a = 1'b1; tick();
    chk("carry_ff", code_a, 16'hDAAA);
    data_in = 8'h00; tick();
    chk("carry_00", code_a, 16'h7000);
    chk("carry_00_valid", 16'(cv_a), 16'h1);

    // Tail insertion with a held byte behind it
    data_in = 8'hFF; data_last = 1'b1; tick();
    chk("tail_data", code_a, 16'hDAAA);
    chk("tail_data_last", 16'(cl_a), 16'h0);
    chk("tail_ready_low", 16'(ready_a), 16'h0);
    data_in = 8'h80; data_last = 1'b0; tick();
    chk("tail_word", code_a, 16'h7000);
    chk("tail_word_last", 16'(cl_a), 16'h1);
    chk("tail_word_valid", 16'(cv_a), 16'h1);
    chk("tail_ready_back", 16'(ready_a), 16'h1);
    tick();
    chk("held_byte", code_a, 16'hEC00);
    chk("held_byte_last", 16'(cl_a), 16'h0);
    valid_a = 1'b0;

    // Reset while in TAIL discards the pending tail word
    data_in = 8'hFF; data_last = 1'b1; valid_a = 1'b1; tick();
    chk("pre_rst_word", code_a, 16'hDAAA);
    valid_a = 1'b0; data_last = 1'b0;
    rst = 1'b1; #2;
    chk("midrst_valid", 16'(cv_a), 16'h0);
    chk("midrst_code", code_a, 16'h0000);
    chk("midrst_ready", 16'(ready_a), 16'h1);
    tick();
    chk("midrst_no_tail", 16'(cv_a), 16'h0);
    rst = 1'b0;
    data_in = 8'h80; valid_a = 1'b1; tick();
    chk("post_rst_enc", code_a, 16'hEC00);
    valid_a = 1'b0; tick();

    // Back-to-back frame of four bytes against the reference model
    bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'h0F; bytes[3] = 8'h81;
    s_ref = 2'b00;
    valid_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_in   = bytes[k];
      data_last = (k == 3);
      tick();
      exp_w = ref_enc(bytes[k], s_ref);
      chk($sformatf("b2b_word%0d", k), code_a, exp_w);
      chk($sformatf("b2b_valid%0d", k), 16'(cv_a), 16'h1);
      chk($sformatf("b2b_last%0d", k), 16'(cl_a), 16'h0);
    end
    valid_a = 1'b0; data_last = 1'b0;
    tick();
    exp_w = ref_enc(8'h00, s_ref);
    chk("b2b_tail", code_a, exp_w);
    chk("b2b_tail_valid", 16'(cv_a), 16'h1);
    chk("b2b_tail_last", 16'(cl_a), 16'h1);
    tick();
    chk("b2b_idle", 16'(cv_a), 16'h0);

    // No-tail variant clears state on the last byte
    data_in = 8'hFF; data_last = 1'b1; valid_b = 1'b1; tick();
    chk("notail_word", code_b, 16'hDAAA);
    chk("notail_last", 16'(cl_b), 16'h1);
    chk("notail_ready", 16'(ready_b), 16'h1);
    data_in = 8'h80; data_last = 1'b0; tick();
    chk("notail_cleared", code_b, 16'hEC00);
    chk("notail_next_last", 16'(cl_b), 16'h0);
    valid_b = 1'b0; tick();
    chk("notail_idle", 16'(cv_b), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
